ring_nic: RTL and testbench

RING_NIC -- requirements
Module: ring_nic

---
 rtl/ring_nic_pkg.sv | 19 +
 rtl/ring_nic_if.sv | 25 ++
 rtl/nic_channel_buf.sv | 30 +++
 rtl/ring_nic.sv | 71 +++++++
 tb/tb_ring_nic.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ring_nic_pkg.sv
// Shared definitions for the ring NIC: processor register map, VC bit position
// and the status-word helper used by both the NIC and its processor-side users.
package ring_nic_pkg;

    localparam int DATA_W = 64;
    localparam int VC_BIT = 0;

    typedef enum logic [1:0] {
        REG_IN_BUF   = 2'b00,
        REG_IN_STAT  = 2'b01,
        REG_OUT_BUF  = 2'b10,
        REG_OUT_STAT = 2'b11
    } nic_reg_e;

    function automatic logic [0:DATA_W-1] status_word(input logic full);
        return {{(DATA_W-1){1'b0}}, full};
    endfunction

endpackage

// File: rtl/ring_nic_if.sv
// Processor load/store port and router link of the ring NIC, bundled together.
interface ring_nic_if;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_channel_buf.sv
// Single-entry 64-bit packet buffer with a full flag; load takes priority over clear.
module nic_channel_buf (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [0:63] i_data,
    output logic [0:63] o_data,
    output logic        o_full
);

    logic [0:63] r_data;
    logic        r_full;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/ring_nic.sv
// Ring network interface: one input and one output packet buffer between a
// processor register port and a two-virtual-channel router link.
module ring_nic
    import ring_nic_pkg::*;
(
    input  logic     CLK,
    input  logic     RESET,
    ring_nic_if.slave bus
);

    logic        w_rd;
    logic        w_wr;
    logic        w_in_load;
    logic        w_in_clear;
    logic        w_in_full;
    logic [0:63] w_ibuf;
    logic        w_out_load;
    logic        w_out_send;
    logic        w_out_full;
    logic [0:63] w_obuf;
    logic [0:63] w_d_out;

    assign w_rd = bus.nicEn & ~bus.nicWrEn;
    assign w_wr = bus.nicEn &  bus.nicWrEn;

    // Accept only when empty, so a fill can never land on a drain cycle.
    assign w_in_load  = bus.net_si & ~w_in_full;
    assign w_in_clear = w_rd & (bus.addr == REG_IN_BUF) & w_in_full;

    // Status is sampled before the drain, so a store during a send is dropped.
    assign w_out_send = w_out_full & bus.net_ro & (bus.net_polarity == w_obuf[VC_BIT]);
    assign w_out_load = w_wr & (bus.addr == REG_OUT_BUF) & ~w_out_full;

    nic_channel_buf u_in_buf (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_load  (w_in_load),
        .i_clear (w_in_clear),
        .i_data  (bus.net_di),
        .o_data  (w_ibuf),
        .o_full  (w_in_full)
    );

    nic_channel_buf u_out_buf (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_load  (w_out_load),
        .i_clear (w_out_send),
        .i_data  (bus.d_in),
        .o_data  (w_obuf),
        .o_full  (w_out_full)
    );

    always_comb begin
        w_d_out = '0;
        if (bus.nicEn && !RESET) begin
            case (bus.addr)
                REG_IN_BUF:   w_d_out = w_ibuf;
                REG_IN_STAT:  w_d_out = status_word(w_in_full);
                REG_OUT_STAT: w_d_out = status_word(w_out_full);
                default:      w_d_out = '0;
            endcase
        end
    end

    assign bus.d_out  = w_d_out;
    assign bus.net_ri = ~RESET & ~w_in_full;
    assign bus.net_so = ~RESET & w_out_send;
    assign bus.net_do = w_obuf;

endmodule

// File: tb/tb_ring_nic.sv
// Directed bench for ring_nic: reset, router receive, processor send with VC
// phase matching, dropped stores and reset with both buffers occupied.
module tb_ring_nic;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [63:0] PKT_RX  = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] PKT_RX2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PKT_RX3 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] PKT_RX4 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] PKT_TX  = 64'h8000_0000_0000_00FF;
    localparam logic [63:0] PKT_TX2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] PKT_Q1  = 64'h0000_0000_0000_0042;
    localparam logic [63:0] PKT_Q2  = 64'h8000_0000_0000_0099;
    localparam logic [63:0] PKT_Q3  = 64'h8000_0000_0000_0777;

    always #5 CLK = ~CLK;

    ring_nic_if nic_bus ();

    ring_nic u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (nic_bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        nic_bus.nicEn   = 1'b0;
        nic_bus.nicWrEn = 1'b0;
        nic_bus.addr    = 2'b00;
        nic_bus.d_in    = '0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [63:0] exp, input string tag);
        nic_bus.nicEn   = 1'b1;
        nic_bus.nicWrEn = 1'b0;
        nic_bus.addr    = a;
        #1;
        chk(tag, nic_bus.d_out, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nic_bus.nicEn   = 1'b1;
        nic_bus.nicWrEn = 1'b1;
        nic_bus.addr    = a;
        nic_bus.d_in    = d;
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        nic_bus.net_si       = 1'b0;
        nic_bus.net_di       = '0;
        nic_bus.net_ro       = 1'b1;
        nic_bus.net_polarity = 1'b0;

        // reset held for five cycles
        for (int i = 0; i < 5; i++) begin
            step();
            nic_bus.nicEn = 1'b1;
            nic_bus.addr  = 2'b01;
            #1;
            chk("rst_net_ri", 64'(nic_bus.net_ri), 64'd0);
            chk("rst_net_so", 64'(nic_bus.net_so), 64'd0);
            chk("rst_d_out", nic_bus.d_out, 64'd0);
        end
        idle();
        RESET = 1'b0;
        step();
        rd_chk(2'b01, 64'd0, "in_stat_after_rst");
        rd_chk(2'b11, 64'd0, "out_stat_after_rst");
        rd_chk(2'b00, 64'd0, "ibuf_after_rst");
        chk("net_ri_after_rst", 64'(nic_bus.net_ri), 64'd1);
        idle();

        // router packet received, read, then status clears
        nic_bus.net_si = 1'b1;
        nic_bus.net_di = PKT_RX;
        step();
        nic_bus.net_si = 1'b0;
        nic_bus.net_di = '0;
        #1;
        chk("rx_net_ri_full", 64'(nic_bus.net_ri), 64'd0);
        rd_chk(2'b01, 64'd1, "rx_in_stat_1");
        rd_chk(2'b00, PKT_RX, "rx_ibuf_data");
        step();
        idle();
        rd_chk(2'b01, 64'd0, "rx_in_stat_0");
        chk("rx_net_ri_free", 64'(nic_bus.net_ri), 64'd1);
        rd_chk(2'b00, PKT_RX, "rx_stale_read");
        step();
        rd_chk(2'b01, 64'd0, "rx_stale_no_change");
        idle();

        // a drain cycle must not accept a new packet
        nic_bus.net_si = 1'b1;
        nic_bus.net_di = PKT_RX2;
        step();
        nic_bus.net_di = PKT_RX3;
        #1;
        chk("drain_net_ri", 64'(nic_bus.net_ri), 64'd0);
        rd_chk(2'b00, PKT_RX2, "drain_read");
        step();
        nic_bus.net_si = 1'b0;
        idle();
        rd_chk(2'b01, 64'd0, "drain_no_accept");
        rd_chk(2'b00, PKT_RX2, "drain_buf_kept");
        idle();

        // store waits for matching VC phase, then sends once
        nic_bus.net_ro       = 1'b1;
        nic_bus.net_polarity = 1'b0;
        wr(2'b10, PKT_TX);
        #1;
        chk("tx_so_same_cycle", 64'(nic_bus.net_so), 64'd0);
        step();
        idle();
        #1;
        chk("tx_so_wrong_vc", 64'(nic_bus.net_so), 64'd0);
        chk("tx_net_do", nic_bus.net_do, PKT_TX);
        rd_chk(2'b11, 64'd1, "tx_out_stat_1");

        // second store while full is dropped
        nic_bus.net_ro = 1'b0;
        wr(2'b10, PKT_TX2);
        step();
        idle();
        nic_bus.net_ro = 1'b1;
        #1;
        chk("tx_drop_so", 64'(nic_bus.net_so), 64'd0);
        chk("tx_drop_keep", nic_bus.net_do, PKT_TX);
        step();
        chk("tx_hold_so", 64'(nic_bus.net_so), 64'd0);
        nic_bus.net_polarity = 1'b1;
        #1;
        chk("tx_send_so", 64'(nic_bus.net_so), 64'd1);
        chk("tx_send_do", nic_bus.net_do, PKT_TX);
        step();
        chk("tx_so_one_pulse", 64'(nic_bus.net_so), 64'd0);
        rd_chk(2'b11, 64'd0, "tx_out_stat_0");
        idle();
        nic_bus.net_polarity = 1'b0;

        // writes to read-only registers are ignored
        wr(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        wr(2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        wr(2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        idle();
        rd_chk(2'b11, 64'd0, "ign_out_stat");
        rd_chk(2'b01, 64'd0, "ign_in_stat");
        chk("ign_net_do", nic_bus.net_do, PKT_TX);
        idle();

        // store in the same cycle as a send is dropped
        wr(2'b10, PKT_Q1);
        step();
        idle();
        #1;
        chk("same_so_q1", 64'(nic_bus.net_so), 64'd1);
        wr(2'b10, PKT_Q2);
        step();
        idle();
        rd_chk(2'b11, 64'd0, "same_cyc_dropped");
        chk("same_cyc_so", 64'(nic_bus.net_so), 64'd0);
        chk("same_cyc_do", nic_bus.net_do, PKT_Q1);
        idle();

        // both buffers full, then d_out decode corners
        nic_bus.net_si = 1'b1;
        nic_bus.net_di = PKT_RX4;
        wr(2'b10, PKT_Q3);
        step();
        nic_bus.net_si = 1'b0;
        idle();
        nic_bus.addr = 2'b01;
        #1;
        chk("d_out_en0", nic_bus.d_out, 64'd0);
        rd_chk(2'b10, 64'd0, "d_out_addr10");
        rd_chk(2'b01, 64'd1, "full_in_stat");
        rd_chk(2'b11, 64'd1, "full_out_stat");
        idle();

        // reset with both buffers full discards both packets
        RESET = 1'b1;
        nic_bus.net_polarity = 1'b1;
        #1;
        chk("rst_full_so", 64'(nic_bus.net_so), 64'd0);
        chk("rst_full_ri", 64'(nic_bus.net_ri), 64'd0);
        step();
        chk("rst_full_so2", 64'(nic_bus.net_so), 64'd0);
        step();
        RESET = 1'b0;
        #1;
        chk("post_rst_so", 64'(nic_bus.net_so), 64'd0);
        rd_chk(2'b01, 64'd0, "post_rst_in_stat");
        rd_chk(2'b11, 64'd0, "post_rst_out_stat");
        rd_chk(2'b00, 64'd0, "post_rst_ibuf");
        chk("post_rst_net_do", nic_bus.net_do, 64'd0);
        idle();
        step();
        chk("post_rst_so_later", 64'(nic_bus.net_so), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
